// File: rtl/iir_stereo_sched.sv
// Round-robin scheduler and shared three-term MAC for the stereo de-emphasis IIR.
// Each channel computes y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1] with private history.
module iir_stereo_sched #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FRAC_BITS  = 10,
    parameter logic [DATA_WIDTH-1:0] B0_COEFF   = DATA_WIDTH'(32'sh000000B2),
    parameter logic [DATA_WIDTH-1:0] B1_COEFF   = DATA_WIDTH'(32'sh000000B2),
    parameter logic [DATA_WIDTH-1:0] A1_COEFF   = DATA_WIDTH'(32'shFFFFFFD6)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] l_dout,
    input  logic                  l_empty,
    output logic                  l_rd_en,
    input  logic [DATA_WIDTH-1:0] r_dout,
    input  logic                  r_empty,
    output logic                  r_rd_en,
    output logic [DATA_WIDTH-1:0] l_out_din,
    output logic                  l_out_wr_en,
    input  logic                  l_out_full,
    output logic [DATA_WIDTH-1:0] r_out_din,
    output logic                  r_out_wr_en,
    input  logic                  r_out_full,
    output logic                  busy,
    output logic                  active_ch
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // run is low through reset and the first edge after it, so no pop is
    // issued while reset_n is asserted even though the grant is combinational.
    logic                  run;
    logic [DATA_WIDTH-1:0] x_cur;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] x_prev [2];
    logic [DATA_WIDTH-1:0] y_prev [2];
    logic                  ch;
    logic                  last_ch;
    logic [1:0]            mac_cnt;

    logic                  grant;
    logic                  grant_ch;
    logic                  wr_fire;
    logic                  out_full_sel;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]  prod;
    logic [DATA_WIDTH-1:0] term;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant arbitration and write handshake; clear overrides all
    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        grant_ch     = 1'b0;
        wr_fire      = 1'b0;
        out_full_sel = ch ? r_out_full : l_out_full;
        case (state)
            IDLE: begin
                if (run) begin
                    if (!l_empty && !r_empty) begin
                        grant    = 1'b1;
                        grant_ch = ~last_ch;
                    end else if (!l_empty) begin
                        grant    = 1'b1;
                        grant_ch = 1'b0;
                    end else if (!r_empty) begin
                        grant    = 1'b1;
                        grant_ch = 1'b1;
                    end
                end
                if (grant) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (mac_cnt == 2'd2) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!out_full_sel) begin
                    wr_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            grant     = 1'b0;
            wr_fire   = 1'b0;
        end
    end

    // Shared multiplier operand select and Q-format scaling
    always_comb begin
        mul_a = x_cur;
        mul_b = B0_COEFF;
        case (mac_cnt)
            2'd1: begin
                mul_a = x_prev[ch];
                mul_b = B1_COEFF;
            end
            2'd2: begin
                mul_a = y_prev[ch];
                mul_b = A1_COEFF;
            end
            default: ;
        endcase
        prod = $signed({{DATA_WIDTH{mul_a[DATA_WIDTH-1]}}, mul_a})
             * $signed({{DATA_WIDTH{mul_b[DATA_WIDTH-1]}}, mul_b});
        term = DATA_WIDTH'(prod >>> FRAC_BITS);
    end

    // Datapath: sample capture, accumulation and history commit on write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            x_cur     <= '0;
            acc       <= '0;
            x_prev[0] <= '0;
            x_prev[1] <= '0;
            y_prev[0] <= '0;
            y_prev[1] <= '0;
            ch        <= 1'b0;
            last_ch   <= 1'b1;
            mac_cnt   <= '0;
        end else begin
            run <= 1'b1;
            if (clear) begin
                acc       <= '0;
                x_prev[0] <= '0;
                x_prev[1] <= '0;
                y_prev[0] <= '0;
                y_prev[1] <= '0;
                last_ch   <= 1'b1;
                mac_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (grant) begin
                            x_cur   <= grant_ch ? r_dout : l_dout;
                            ch      <= grant_ch;
                            acc     <= '0;
                            mac_cnt <= '0;
                        end
                    end
                    ACCUM: begin
                        acc     <= acc + term;
                        mac_cnt <= (mac_cnt == 2'd2) ? 2'd0 : mac_cnt + 2'd1;
                    end
                    WRITE: begin
                        if (wr_fire) begin
                            x_prev[ch] <= x_cur;
                            y_prev[ch] <= acc;
                            last_ch    <= ch;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO strobes and result buses; result is visible only while writing
    assign l_rd_en     = grant & ~grant_ch;
    assign r_rd_en     = grant & grant_ch;
    assign l_out_wr_en = wr_fire & ~ch;
    assign r_out_wr_en = wr_fire & ch;
    assign l_out_din   = (state == WRITE && !ch) ? acc : '0;
    assign r_out_din   = (state == WRITE &&  ch) ? acc : '0;
    assign busy        = (state != IDLE);
    assign active_ch   = ch;

endmodule

// File: tb/tb_iir_stereo_sched.sv
// Scoreboard bench for iir_stereo_sched: FIFO models, expected-result queues
// filled by the stimulus, and a negedge monitor that checks every push.
module tb_iir_stereo_sched;

    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          clear;
    logic [DW-1:0] l_dout;
    logic          l_empty;
    logic          l_rd_en;
    logic [DW-1:0] r_dout;
    logic          r_empty;
    logic          r_rd_en;
    logic [DW-1:0] l_out_din;
    logic          l_out_wr_en;
    logic          l_out_full;
    logic [DW-1:0] r_out_din;
    logic          r_out_wr_en;
    logic          r_out_full;
    logic          busy;
    logic          active_ch;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];
    exp_t          exp_l[$];
    exp_t          exp_r[$];
    int            rdc_l[$];
    int            rdc_r[$];
    int            grant_log[$];
    bit            pop_l, pop_r;
    int            l_rd_cnt, r_rd_cnt, l_wr_cnt, r_wr_cnt;

    iir_stereo_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .l_dout     (l_dout),
        .l_empty    (l_empty),
        .l_rd_en    (l_rd_en),
        .r_dout     (r_dout),
        .r_empty    (r_empty),
        .r_rd_en    (r_rd_en),
        .l_out_din  (l_out_din),
        .l_out_wr_en(l_out_wr_en),
        .l_out_full (l_out_full),
        .r_out_din  (r_out_din),
        .r_out_wr_en(r_out_wr_en),
        .r_out_full (r_out_full),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic refresh();
        l_empty = (lq.size() == 0);
        r_empty = (rq.size() == 0);
        l_dout  = (lq.size() != 0) ? lq[0] : '0;
        r_dout  = (rq.size() != 0) ? rq[0] : '0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [DW-1:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.lat  = lat;
        if (c == 0) exp_l.push_back(e);
        else        exp_r.push_back(e);
    endtask

    // Show-ahead input FIFOs: a pop seen in a cycle takes effect after its edge
    always @(posedge clock) begin
        cyc++;
        #1;
        if (pop_l && lq.size() != 0) void'(lq.pop_front());
        if (pop_r && rq.size() != 0) void'(rq.pop_front());
        pop_l = 1'b0;
        pop_r = 1'b0;
        refresh();
    end

    task automatic check_wr(input int c, input logic [DW-1:0] d);
        exp_t e;
        int   rc;
        total++;
        if ((c == 0 && exp_l.size() == 0) || (c == 1 && exp_r.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_wr ch=%0d got=%h want=none", c, d);
            return;
        end
        if (c == 0) begin
            e  = exp_l.pop_front();
            rc = (rdc_l.size() != 0) ? rdc_l.pop_front() : -1000;
        end else begin
            e  = exp_r.pop_front();
            rc = (rdc_r.size() != 0) ? rdc_r.pop_front() : -1000;
        end
        if (d !== e.data) begin
            bad++;
            $display("FAIL wr_data ch=%0d got=%h want=%h", c, d, e.data);
        end
        total++;
        if (cyc - rc != e.lat) begin
            bad++;
            $display("FAIL wr_latency ch=%0d got=%0d want=%0d", c, cyc - rc, e.lat);
        end
    endtask

    // Monitor: records pops, checks pushes and strobe exclusivity
    always @(negedge clock) begin
        if (reset_n) begin
            if (l_rd_en) begin
                pop_l = 1'b1;
                rdc_l.push_back(cyc);
                grant_log.push_back(0);
                l_rd_cnt++;
            end
            if (r_rd_en) begin
                pop_r = 1'b1;
                rdc_r.push_back(cyc);
                grant_log.push_back(1);
                r_rd_cnt++;
            end
            if ((l_rd_en && r_rd_en) || ((l_rd_en || r_rd_en) && (l_out_wr_en || r_out_wr_en))) begin
                total++;
                bad++;
                $display("FAIL strobe_excl rd=%b%b wr=%b%b want at most one", l_rd_en, r_rd_en, l_out_wr_en, r_out_wr_en);
            end
            if (!busy && (l_out_din != '0 || r_out_din != '0)) begin
                total++;
                bad++;
                $display("FAIL din_idle got=%h/%h want=0", l_out_din, r_out_din);
            end
            if (l_out_wr_en) begin
                l_wr_cnt++;
                check_wr(0, l_out_din);
            end
            if (r_out_wr_en) begin
                r_wr_cnt++;
                check_wr(1, r_out_din);
            end
        end
    end

    task automatic start_reset();
        reset_n    = 1'b0;
        clear      = 1'b0;
        l_out_full = 1'b0;
        r_out_full = 1'b0;
        lq.delete();
        rq.delete();
        exp_l.delete();
        exp_r.delete();
        rdc_l.delete();
        rdc_r.delete();
        grant_log.delete();
        pop_l = 1'b0;
        pop_r = 1'b0;
        l_rd_cnt = 0;
        r_rd_cnt = 0;
        l_wr_cnt = 0;
        r_wr_cnt = 0;
        refresh();
    endtask

    task automatic release_reset();
        refresh();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((exp_l.size() != 0 || exp_r.size() != 0 || busy) && k < 300) begin
            @(negedge clock);
            #1;
            k++;
        end
        total++;
        if (k >= 300) begin
            bad++;
            $display("FAIL %s_timeout got=%0d/%0d pending want=0", name, exp_l.size(), exp_r.size());
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_l_rd(input int n);
        int k = 0;
        while (l_rd_cnt < n && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        total++;
        if (l_rd_cnt < n) begin
            bad++;
            $display("FAIL wait_l_rd got=%0d want=%0d", l_rd_cnt, n);
        end
    endtask

    initial begin
        int exp_order[4];
        int sl, sr, sw;
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 0;
        exp_order[3] = 1;

        // Reset with both inputs loaded, then round-robin
        start_reset();
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        rq.push_back(32'd1024);
        rq.push_back(32'd1024);
        refresh();
        @(negedge clock);
        check("rst_l_rd_en", 32'(l_rd_en), 32'd0);
        check("rst_r_rd_en", 32'(r_rd_en), 32'd0);
        check("rst_l_wr_en", 32'(l_out_wr_en), 32'd0);
        check("rst_r_wr_en", 32'(r_out_wr_en), 32'd0);
        check("rst_l_din", l_out_din, 32'd0);
        check("rst_r_din", r_out_din, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_active_ch", 32'(active_ch), 32'd0);
        push_exp(0, 32'd178, 4);
        push_exp(1, 32'd178, 4);
        push_exp(0, 32'd348, 4);
        push_exp(1, 32'd348, 4);
        release_reset();
        wait_done("rr");
        check("rr_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        end

        // Left-only step response
        start_reset();
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        push_exp(0, 32'd178, 4);
        push_exp(0, 32'd348, 4);
        release_reset();
        wait_done("step");
        check("step_r_rd", 32'(r_rd_cnt), 32'd0);
        check("step_r_wr", 32'(r_wr_cnt), 32'd0);
        check("step_l_wr", 32'(l_wr_cnt), 32'd2);

        // Backpressure: full for 10 cycles from the first WRITE
        start_reset();
        l_out_full = 1'b1;
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        push_exp(0, 32'd178, 14);
        push_exp(0, 32'd348, 4);
        push_exp(0, 32'd341, 4);
        release_reset();
        wait_l_rd(1);
        repeat (14) @(posedge clock);
        sl = l_rd_cnt;
        sr = r_rd_cnt;
        sw = l_wr_cnt;
        check("bp_no_wr", 32'(sw), 32'd0);
        check("bp_no_rd", 32'(sl + sr), 32'd1);
        #1 l_out_full = 1'b0;
        wait_done("bp");
        check("bp_l_wr", 32'(l_wr_cnt), 32'd3);

        // Clear during the second coefficient of the second left sample
        start_reset();
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        lq.push_back(32'd1024);
        push_exp(0, 32'd178, 4);
        push_exp(0, 32'd178, 4);
        release_reset();
        wait_l_rd(2);
        @(posedge clock);
        @(posedge clock);
        #1 clear = 1'b1;
        if (rdc_l.size() != 0) void'(rdc_l.pop_back());
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check("clr_busy", 32'(busy), 32'd0);
        wait_done("clr");
        check("clr_l_wr", 32'(l_wr_cnt), 32'd2);

        // Negative input
        start_reset();
        lq.push_back(32'hFFFFFC00);
        push_exp(0, 32'hFFFFFF4E, 4);
        release_reset();
        wait_done("neg");
        check("neg_l_wr", 32'(l_wr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
